// File: rtl/ex_muldiv_unit_if.sv
// Handshake and data bundle between the EX-stage pipeline glue and the
// iterative multiply/divide unit.
interface ex_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             stall_req;

    // Pipeline side: issues operations and consumes results/stall.
    modport master (
        output start, funct3, op_a, op_b, flush,
        input  busy, done, result, stall_req
    );

    // Unit side.
    modport slave (
        input  start, funct3, op_a, op_b, flush,
        output busy, done, result, stall_req
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes,
// one bit per cycle; signs are fixed up on the final iteration. Divide by
// zero and signed overflow skip the iterations and finish the next cycle.
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    ex_muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state, state_next;
    logic [1:0]         f3;        // product half / quotient-vs-remainder select
    logic               neg_q;     // product or quotient needs negation
    logic               neg_r;     // remainder takes the dividend sign
    logic [WIDTH-1:0]   mcand;     // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc;       // mul: {hi, multiplier}; div: {rem, quotient}
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   result;

    // Operand decode, only meaningful while IDLE
    logic               a_signed, b_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               div_zero, div_ovf, special;
    logic [WIDTH-1:0]   special_res;

    // Iteration datapath
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_part, div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic               last;

    // Final-iteration result selection
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo_raw, rem_raw, quo, rem;
    logic [WIDTH-1:0]   mul_res, div_res;

    // Operand signedness, magnitudes and early-out divide cases
    always_comb begin
        a_signed = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
        b_signed = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1];
        a_neg    = a_signed & bus.op_a[WIDTH-1];
        b_neg    = b_signed & bus.op_b[WIDTH-1];
        a_mag    = a_neg ? -bus.op_a : bus.op_a;
        b_mag    = b_neg ? -bus.op_b : bus.op_b;
        div_zero = bus.funct3[2] & (bus.op_b == '0);
        div_ovf  = bus.funct3[2] & ~bus.funct3[0]
                 & (bus.op_a == {1'b1, {(WIDTH-1){1'b0}}}) & (bus.op_b == '1);
        special  = div_zero | div_ovf;
        special_res = '0;
        if (div_zero)
            special_res = bus.funct3[1] ? bus.op_a : '1;
        else if (div_ovf)
            special_res = bus.funct3[1] ? '0 : bus.op_a;
    end

    // One multiply step and one restoring-divide step per cycle
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};
        div_part = acc[2*WIDTH-1:WIDTH-1];
        div_diff = div_part - {1'b0, mcand};
        div_next = div_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                   : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        last     = (cnt == CW'(WIDTH-1));
    end

    // Sign fix-up and result selection for the last iteration
    always_comb begin
        prod    = neg_q ? -mul_next : mul_next;
        mul_res = (f3 == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
        quo_raw = div_next[WIDTH-1:0];
        rem_raw = div_next[2*WIDTH-1:WIDTH];
        quo     = neg_q ? -quo_raw : quo_raw;
        rem     = neg_r ? -rem_raw : rem_raw;
        div_res = f3[1] ? rem : quo;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state and status outputs; flush always returns to IDLE
    always_comb begin
        state_next = state;
        bus.busy   = (state != IDLE);
        bus.done   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.flush)
                    state_next = special ? DONE : (bus.funct3[2] ? DIV : MUL);
            end
            MUL, DIV: begin
                if (bus.flush)  state_next = IDLE;
                else if (last)  state_next = DONE;
            end
            DONE: begin
                bus.done   = ~bus.flush;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand latch, iteration registers and result register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f3     <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            mcand  <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
        end else if (!bus.flush) begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        f3    <= bus.funct3[1:0];
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        mcand <= b_mag;
                        acc   <= {{WIDTH{1'b0}}, a_mag};
                        cnt   <= '0;
                        if (special) result <= special_res;
                    end
                end
                MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + CW'(1);
                    if (last) result <= mul_res;
                end
                DIV: begin
                    acc <= div_next;
                    cnt <= cnt + CW'(1);
                    if (last) result <= div_res;
                end
                default: ;
            endcase
        end
    end

    assign bus.result    = result;
    assign bus.stall_req = bus.start & ~bus.done;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed-vector bench for ex_muldiv_unit: results, done latency, stall
// window, flush and asynchronous reset behaviour.
module tb_ex_muldiv_unit;
    localparam int WIDTH = 32;

    localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010,
                           F_MULHU = 3'b011, F_DIV = 3'b100, F_DIVU = 3'b101,
                           F_REM = 3'b110, F_REMU = 3'b111;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ex_muldiv_unit_if #(.WIDTH(WIDTH)) bus ();
    ex_muldiv_unit #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    int          checks = 0;
    int          failures = 0;
    logic [31:0] last_res = '0;
    logic [31:0] res_at_start = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Issue one op in the next cycle, wait for done, check latency/result/stall
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_cyc);
        int cyc = 0;
        int stall_bad = 0;
        bit seen = 0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.flush = 1'b0;
        bus.funct3 = f3; bus.op_a = a; bus.op_b = b;
        while (!seen && cyc < 80) begin
            @(negedge clk);
            if (cyc == 0) begin
                res_at_start = bus.result;
                check({tag, " busy_c0"}, 32'(bus.busy), 32'd0);
            end
            if (cyc == 1) check({tag, " busy_c1"}, 32'(bus.busy), 32'd1);
            if (bus.done) seen = 1;
            else begin
                if (!bus.stall_req) stall_bad++;
                @(posedge clk); #1;
                cyc++;
            end
        end
        check({tag, " done_cyc"}, seen ? 32'(cyc) : 32'hFFFF_FFFF, 32'(exp_cyc));
        check({tag, " result"}, bus.result, exp_res);
        check({tag, " stall_lo_done"}, 32'(bus.stall_req), 32'd0);
        check({tag, " stall_hi_cnt"}, 32'(stall_bad), 32'd0);
        last_res = exp_res;
    endtask

    // Drop start and confirm no done pulses appear while idle
    task automatic idle(input string tag, input int n);
        int d = 0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (bus.done) d++;
            @(posedge clk); #1;
        end
        check({tag, " stray_done"}, 32'(d), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int dones;
        reset = 1'b1;
        bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = '0; bus.op_a = '0; bus.op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst done", 32'(bus.done), 32'd0);
        check("rst result", bus.result, 32'd0);
        reset = 1'b0;

        // Multiply variants
        run_op("mul 7*-3",      F_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op("mulh 7*-3",     F_MULH,   32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        run_op("mulh min*min",  F_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33);
        run_op("mulhu min*min", F_MULHU,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33);
        run_op("mulhsu -1*max", F_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        idle("after mul", 3);

        // Divide variants
        run_op("div -7/2",      F_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
        run_op("rem -7/2",      F_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
        run_op("divu 100/7",    F_DIVU,   32'd100,        32'd7,         32'd14,        33);
        run_op("remu 100/7",    F_REMU,   32'd100,        32'd7,         32'd2,         33);

        // Early-out cases
        run_op("divu 5/0",      F_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        run_op("rem 5/0",       F_REM,    32'd5,          32'd0,         32'd5,         1);
        run_op("div ovf",       F_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem ovf",       F_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);

        // Unsigned with all-ones divisor is a normal divide
        run_op("divu min/max",  F_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         33);
        run_op("divu max/1",    F_DIVU,   32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 33);
        idle("after div", 2);

        // Flush a DIV in its cycle 10, restart a MUL in cycle 11
        dones = 0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.funct3 = F_DIVU; bus.op_a = 32'd1000; bus.op_b = 32'd7;
        for (int c = 0; c <= 10; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (c == 10) bus.flush = 1'b1;
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("flush no_done", 32'(dones), 32'd0);
        run_op("mulhu after flush", F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        check("flush result_kept", res_at_start, 32'hFFFF_FFFF);
        idle("after flush", 2);

        // Asynchronous reset in cycle 15 of a MUL
        @(posedge clk); #1;
        bus.start = 1'b1; bus.funct3 = F_MUL; bus.op_a = 32'd3; bus.op_b = 32'd5;
        repeat (15) @(posedge clk);
        #1;
        reset = 1'b1;
        bus.start = 1'b0;
        #1;
        check("midrst busy", 32'(bus.busy), 32'd0);
        check("midrst done", 32'(bus.done), 32'd0);
        check("midrst result", bus.result, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        run_op("mul 1000*1000",  F_MUL,  32'd1000,    32'd1000, 32'h000F_4240, 33);
        run_op("divu 1e6/1000",  F_DIVU, 32'h000F_4240, 32'd1000, 32'd1000,    33);
        idle("after rst", 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative RV32M multiply/divide unit in the EX stage, fed by the ID/EX pipeline register outputs (operands, funct3) and producing a result for the EX/MEM register's ALU input. While an operation is in flight it raises a stall request that freezes IF/ID and holds ID/EX, so operands stay stable for the whole computation. Radix-2 shift-add multiply and restoring divide; divide-by-zero and overflow cases complete early.

## Interface
- WIDTH, 32, datapath width; iteration count equals WIDTH
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  valid M-extension instruction present in EX (opcode OP, funct7=0000001)
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  in  WIDTH  rs1 value (post-forwarding)
- op_b  in  WIDTH  rs2 value (post-forwarding)
- flush  in  1  kill in-flight operation (branch/jump redirect)
- busy  out  1  FSM not IDLE
- done  out  1  one-cycle pulse, result valid
- result  out  WIDTH  selected product half / quotient / remainder; held until next done
- stall_req  out  1  start & ~done (combinational); drives stall to IF/ID and hold to ID/EX

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE: on start & ~flush, latch funct3, operand signs, magnitudes. Signed ops: MUL/MULH/DIV/REM both signed; MULHSU only op_a signed; others unsigned. Go to MUL (funct3[2]=0) or DIV; special divide cases go directly to DONE.
- MUL: 2*WIDTH-bit accumulator; each cycle add multiplicand if multiplier LSB set, shift. After WIDTH iterations → DONE. Negate 2*WIDTH product if exactly one operand negative. MUL returns low half; MULH/MULHSU/MULHU return high half.
- DIV: restoring on magnitudes, one quotient bit per cycle, WIDTH iterations → DONE. Quotient negated if signs differ; remainder takes dividend sign.
- Special cases (decided in IDLE, no iterations): op_b=0 → quotient all ones (DIV and DIVU), remainder = op_a. Signed overflow (op_a = 1<<(WIDTH-1), op_b = all ones) → quotient = op_a, remainder 0.
- DONE: done=1, result updated on entry, busy=1; unconditionally → IDLE. start ignored in MUL/DIV/DONE.
- flush: in any state, next state IDLE, no done, result unchanged. flush beats start in IDLE.
- Reset (any time, including mid-operation): state IDLE, busy 0, done 0, result 0, internal registers 0.

## Timing
- Cycle 0 = first cycle start is high in IDLE. Normal op: MUL/DIV during cycles 1..WIDTH, done=1 in cycle WIDTH+1 (cycle 33 for WIDTH=32). Special divide: done in cycle 1.
- stall_req high cycles 0..WIDTH, low in done cycle so the pipeline advances on that edge and EX/MEM captures result.
- start still high in IDLE the cycle after DONE is a new instruction and begins a new operation (back-to-back ops; no idle bubble required).
- busy low only in IDLE; rises cycle 1.
- Arithmetic modulo 2^WIDTH; no exceptions raised.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), start cycle 0 → done cycle 33, result 0xFFFFFFEB; MULH same → 0xFFFFFFFF; stall_req high cycles 0..32.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU same → 0x40000000; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 100/7 → 14, REMU → 2; each done cycle 33.
- DIVU 5/0 → 0xFFFFFFFF, REM 5/0 → 5, DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0; each done cycle 1.
- flush at cycle 10 of a DIV → busy 0 cycle 11, no done pulse, result retains prior value; new MUL started cycle 11 completes correctly cycle 44.
- reset asserted mid-MUL (cycle 15) → busy, done, result 0 immediately; after release, back-to-back MUL then DIVU yield correct results with no stray done.
